instruction_decode: RTL and testbench
=====================================

// Module: instruction_decode
// PURPOSE
//  RV32I instruction-decode pipeline stage between fetch and execute.
//  - Holds the 32x32 integer register file.
//  - Splits each fetched instruction into register indices, a sign-extended immediate and control strobes.
//  - Registers all results into the ID/EX pipeline register, advanced by enable.
// PARAMETERS
//  XLEN     32  data/PC width
//  NREGS    32  register count (x0 hardwired to zero)
// PORTS
//  clk          in   1     rising-edge clock (the only clock)
//  reset        in   1     asynchronous, active-low reset
//  enable       in   1     stage advance; 0 = stall, hold all outputs
//  flush        in   1     insert bubble (priority over enable)
//  instr_valid  in   1     instr/pc_in carry a real instruction
//  instr        in   32    fetched instruction word
//  pc_in        in   XLEN  PC of instr
//  wb_en        in   1     register-file write strobe
//  wb_rd        in   5     write index
//  wb_data      in   XLEN  write data
//  id_valid     out  1     output bundle holds a valid instruction
//  pc_out       out  XLEN  registered pc_in
//  rs1,rs2,rd   out  5     instr[19:15], instr[24:20], instr[11:7]
//  rs1_data     out  XLEN  register operand 1
//  rs2_data     out  XLEN  register operand 2
//  imm          out  XLEN  sign-extended immediate
//  alu_op       out  4     0 ADD,1 SUB,2 SLL,3 SLT,4 SLTU,5 XOR,6 SRL,7 SRA,8 OR,9 AND,10 PASSB
//  alu_src_imm  out  1     ALU operand B = imm
//  reg_write    out  1     instruction writes rd
//  mem_read     out  1     load
//  mem_write    out  1     store
//  mem_size     out  3     funct3 of the load/store
//  branch       out  1     conditional branch; funct3 in mem_size
//  jump         out  1     JAL
//  jalr         out  1     JALR
//  auipc        out  1     AUIPC
//  illegal      out  1     unsupported opcode or funct field
// BEHAVIOUR
//  Reset (reset=0, async):
//  - All outputs and all 32 registers clear to 0; no clock needed.
//  Pipeline register update (rising edge, reset=1), in priority order:
//  - flush=1: id_valid=0 and every control strobe=0.
//  - else enable=1: latch the decode of instr; id_valid=instr_valid.
//  - else (enable=0): hold every output unchanged.
//  - instr_valid=0 latches a bubble: same result as a flush.
//  Immediate formats, sign-extended from instr[31]:
//  - I: loads, OP-IMM, JALR.
//  - S: stores.
//  - B: branches, bit0=0.
//  - U: LUI/AUIPC, imm[11:0]=0.
//  - J: JAL, bit0=0.
//  - R-type: imm=0.
//  Opcode decode:
//  - OP/OP-IMM: alu_op from funct3 and instr[30]. SUB/SRA use instr[30]; OP-IMM ignores instr[30] except on SRAI.
//  - LUI: alu_op=PASSB, alu_src_imm=1, reg_write=1.
//  - Loads/stores: alu_op=ADD, alu_src_imm=1.
//  - Branches: alu_op=SUB, reg_write=0.
//  - JAL/JALR: reg_write=1.
//  - Illegal instruction: illegal=1 and reg_write=mem_read=mem_write=branch=jump=jalr=0.
//  Register file:
//  - 2 combinational read ports plus 1 write.
//  - Write occurs on a rising edge when wb_en=1 and wb_rd!=0, regardless of enable/flush.
//  - x0 always reads 0.
//  - Write-through bypass: a same-edge write to rs1/rs2 (index !=0) supplies wb_data to the latched operand.
//  - Operands are read during the enable cycle; stalled outputs are not refreshed by later writebacks.
//  Latency: exactly 1 cycle from instr to outputs when enable=1.
// TESTING
//  - Reset: reset=0 mid-stream -> all outputs 0 immediately. After release, reading x1..x31 returns 0.
//  - 0x00500093 (addi x1,x0,5), enable=1 -> rd=1, rs1=0, imm=5, alu_op=0, alu_src_imm=1, reg_write=1, id_valid=1.
//  - 0x0020A423 (sw x2,8(x1)) -> imm=8, mem_write=1, mem_size=2, reg_write=0.
//  - 0x0020A423 (sw x2,8(x1)) then 0x123452B7 (lui x5,0x12345) -> imm=0x12345000, alu_op=10, rd=5.
//  - 0xFE208EE3 (beq x1,x2,-4) -> branch=1, imm=0xFFFFFFFC, alu_op=1.
//  - Bypass: wb_en=1, wb_rd=1, wb_data=0xDEADBEEF on the same edge as decoding rs1=x1 -> rs1_data=0xDEADBEEF.
//  - Write to x0: wb_rd=0 write -> x0 still reads 0.
//  - Stall/flush: enable=0 for 3 cycles -> outputs hold. flush=1 with enable=1 -> id_valid=0, strobes 0.
//  - Illegal: 0xFFFFFFFF -> illegal=1, no write strobes.

Source files
------------

// File: rtl/instruction_decode_if.sv
// ---------------------------------------------------------------------------
// instruction_decode_if
// Bundle between the fetch/writeback side and the RV32I decode stage.
//   master : drives enable, flush, instr_valid, instr, pc_in, wb_en, wb_rd,
//            wb_data and observes the registered ID/EX bundle.
//   slave  : the decode stage; consumes the above and drives id_valid,
//            pc_out, rs1/rs2/rd, rs1_data/rs2_data, imm and control strobes.
// ---------------------------------------------------------------------------
interface instruction_decode_if #(
  parameter int XLEN = 32
);
  logic            enable;
  logic            flush;
  logic            instr_valid;
  logic [31:0]     instr;
  logic [XLEN-1:0] pc_in;
  logic            wb_en;
  logic [4:0]      wb_rd;
  logic [XLEN-1:0] wb_data;

  logic            id_valid;
  logic [XLEN-1:0] pc_out;
  logic [4:0]      rs1;
  logic [4:0]      rs2;
  logic [4:0]      rd;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic [XLEN-1:0] imm;
  logic [3:0]      alu_op;
  logic            alu_src_imm;
  logic            reg_write;
  logic            mem_read;
  logic            mem_write;
  logic [2:0]      mem_size;
  logic            branch;
  logic            jump;
  logic            jalr;
  logic            auipc;
  logic            illegal;

  modport master (
    output enable, flush, instr_valid, instr, pc_in, wb_en, wb_rd, wb_data,
    input  id_valid, pc_out, rs1, rs2, rd, rs1_data, rs2_data, imm, alu_op,
           alu_src_imm, reg_write, mem_read, mem_write, mem_size, branch,
           jump, jalr, auipc, illegal
  );

  modport slave (
    input  enable, flush, instr_valid, instr, pc_in, wb_en, wb_rd, wb_data,
    output id_valid, pc_out, rs1, rs2, rd, rs1_data, rs2_data, imm, alu_op,
           alu_src_imm, reg_write, mem_read, mem_write, mem_size, branch,
           jump, jalr, auipc, illegal
  );
endinterface

// File: rtl/instruction_decode.sv
// ---------------------------------------------------------------------------
// instruction_decode
// RV32I decode stage: 32x32 register file, field split, immediate
// generation and control decode, registered into the ID/EX bundle.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset (clears outputs and registers)
//   bus   : instruction_decode_if.slave (fetch inputs, writeback port,
//           registered ID/EX outputs)
// ---------------------------------------------------------------------------
module instruction_decode #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  instruction_decode_if.slave  bus
);

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_PASSB = 4'd10;

  typedef enum logic [2:0] {FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J} imm_fmt_t;

  function automatic logic signed [XLEN-1:0] imm_gen(input imm_fmt_t fmt, input logic [31:0] i);
    logic signed [31:0] raw;
    case (fmt)
      FMT_I:   raw = {{20{i[31]}}, i[31:20]};
      FMT_S:   raw = {{20{i[31]}}, i[31:25], i[11:7]};
      FMT_B:   raw = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      FMT_U:   raw = {i[31:12], 12'b0};
      FMT_J:   raw = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      default: raw = '0;
    endcase
    return XLEN'(raw);
  endfunction

  // alt selects SUB/SRA; callers mask it for OP-IMM so ADDI never becomes SUB.
  function automatic logic [3:0] alu_decode(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  return alt ? ALU_SUB : ALU_ADD;
      3'b001:  return 4'd2;
      3'b010:  return 4'd3;
      3'b011:  return 4'd4;
      3'b100:  return 4'd5;
      3'b101:  return alt ? 4'd7 : 4'd6;
      3'b110:  return 4'd8;
      default: return 4'd9;
    endcase
  endfunction

  logic [XLEN-1:0] regs [NREGS];

  logic [6:0]      opcode;
  logic [2:0]      f3;
  logic [6:0]      f7;
  logic [4:0]      rs1_idx, rs2_idx;
  imm_fmt_t        imm_fmt_p0;
  logic [XLEN-1:0] imm_p0, rs1_data_p0, rs2_data_p0;
  logic [3:0]      alu_op_p0;
  logic [2:0]      mem_size_p0;
  logic            alu_src_imm_p0, reg_write_p0, mem_read_p0, mem_write_p0;
  logic            branch_p0, jump_p0, jalr_p0, auipc_p0, illegal_p0;
  logic            live;

  assign opcode  = bus.instr[6:0];
  assign f3      = bus.instr[14:12];
  assign f7      = bus.instr[31:25];
  assign rs1_idx = bus.instr[19:15];
  assign rs2_idx = bus.instr[24:20];
  assign live    = bus.instr_valid & ~bus.flush;

  // Operand read with same-edge writeback forwarded; x0 is forced to zero.
  always_comb begin
    rs1_data_p0 = regs[rs1_idx];
    rs2_data_p0 = regs[rs2_idx];
    if (bus.wb_en && bus.wb_rd == rs1_idx) rs1_data_p0 = bus.wb_data;
    if (bus.wb_en && bus.wb_rd == rs2_idx) rs2_data_p0 = bus.wb_data;
    if (rs1_idx == 5'd0) rs1_data_p0 = '0;
    if (rs2_idx == 5'd0) rs2_data_p0 = '0;
  end

  // Control strobes are only raised on the legal path, so illegal leaves them 0.
  always_comb begin
    imm_fmt_p0     = FMT_R;
    alu_op_p0      = ALU_ADD;
    alu_src_imm_p0 = 1'b0;
    reg_write_p0   = 1'b0;
    mem_read_p0    = 1'b0;
    mem_write_p0   = 1'b0;
    mem_size_p0    = 3'b000;
    branch_p0      = 1'b0;
    jump_p0        = 1'b0;
    jalr_p0        = 1'b0;
    auipc_p0       = 1'b0;
    illegal_p0     = 1'b0;
    case (opcode)
      OPC_OP: begin
        if (f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'b000 || f3 == 3'b101))) begin
          alu_op_p0    = alu_decode(f3, bus.instr[30]);
          reg_write_p0 = 1'b1;
        end else illegal_p0 = 1'b1;
      end
      OPC_OPIMM: begin
        if ((f3 == 3'b001 && f7 != 7'h00) ||
            (f3 == 3'b101 && f7 != 7'h00 && f7 != 7'h20)) illegal_p0 = 1'b1;
        else begin
          imm_fmt_p0     = FMT_I;
          alu_op_p0      = alu_decode(f3, (f3 == 3'b101) & bus.instr[30]);
          alu_src_imm_p0 = 1'b1;
          reg_write_p0   = 1'b1;
        end
      end
      OPC_LUI: begin
        imm_fmt_p0     = FMT_U;
        alu_op_p0      = ALU_PASSB;
        alu_src_imm_p0 = 1'b1;
        reg_write_p0   = 1'b1;
      end
      OPC_AUIPC: begin
        imm_fmt_p0     = FMT_U;
        alu_src_imm_p0 = 1'b1;
        reg_write_p0   = 1'b1;
        auipc_p0       = 1'b1;
      end
      OPC_JAL: begin
        imm_fmt_p0   = FMT_J;
        reg_write_p0 = 1'b1;
        jump_p0      = 1'b1;
      end
      OPC_JALR: begin
        if (f3 == 3'b000) begin
          imm_fmt_p0     = FMT_I;
          alu_src_imm_p0 = 1'b1;
          reg_write_p0   = 1'b1;
          jalr_p0        = 1'b1;
        end else illegal_p0 = 1'b1;
      end
      OPC_BRANCH: begin
        if (f3 != 3'b010 && f3 != 3'b011) begin
          imm_fmt_p0  = FMT_B;
          alu_op_p0   = ALU_SUB;
          branch_p0   = 1'b1;
          mem_size_p0 = f3;
        end else illegal_p0 = 1'b1;
      end
      OPC_LOAD: begin
        if (f3 != 3'b011 && f3 != 3'b110 && f3 != 3'b111) begin
          imm_fmt_p0     = FMT_I;
          alu_src_imm_p0 = 1'b1;
          reg_write_p0   = 1'b1;
          mem_read_p0    = 1'b1;
          mem_size_p0    = f3;
        end else illegal_p0 = 1'b1;
      end
      OPC_STORE: begin
        if (f3 == 3'b000 || f3 == 3'b001 || f3 == 3'b010) begin
          imm_fmt_p0     = FMT_S;
          alu_src_imm_p0 = 1'b1;
          mem_write_p0   = 1'b1;
          mem_size_p0    = f3;
        end else illegal_p0 = 1'b1;
      end
      default: illegal_p0 = 1'b1;
    endcase
    imm_p0 = imm_gen(imm_fmt_p0, bus.instr);
  end

  // Register file write port: independent of stall/flush; x0 never written.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (bus.wb_en && bus.wb_rd != 5'd0) begin
      regs[bus.wb_rd] <= bus.wb_data;
    end
  end

  // ---- ID/EX boundary: data fields move only on an unflushed enable,
  // ---- control moves on enable or flush and is zeroed for bubbles.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.id_valid    <= 1'b0;
      bus.pc_out      <= '0;
      bus.rs1         <= '0;
      bus.rs2         <= '0;
      bus.rd          <= '0;
      bus.rs1_data    <= '0;
      bus.rs2_data    <= '0;
      bus.imm         <= '0;
      bus.alu_op      <= ALU_ADD;
      bus.alu_src_imm <= 1'b0;
      bus.reg_write   <= 1'b0;
      bus.mem_read    <= 1'b0;
      bus.mem_write   <= 1'b0;
      bus.mem_size    <= 3'b000;
      bus.branch      <= 1'b0;
      bus.jump        <= 1'b0;
      bus.jalr        <= 1'b0;
      bus.auipc       <= 1'b0;
      bus.illegal     <= 1'b0;
    end else begin
      if (bus.enable && !bus.flush) begin
        bus.pc_out   <= bus.pc_in;
        bus.rs1      <= rs1_idx;
        bus.rs2      <= rs2_idx;
        bus.rd       <= bus.instr[11:7];
        bus.rs1_data <= rs1_data_p0;
        bus.rs2_data <= rs2_data_p0;
        bus.imm      <= imm_p0;
      end
      if (bus.enable || bus.flush) begin
        bus.id_valid    <= live;
        bus.alu_op      <= live ? alu_op_p0 : ALU_ADD;
        bus.mem_size    <= live ? mem_size_p0 : 3'b000;
        bus.alu_src_imm <= live & alu_src_imm_p0;
        bus.reg_write   <= live & reg_write_p0;
        bus.mem_read    <= live & mem_read_p0;
        bus.mem_write   <= live & mem_write_p0;
        bus.branch      <= live & branch_p0;
        bus.jump        <= live & jump_p0;
        bus.jalr        <= live & jalr_p0;
        bus.auipc       <= live & auipc_p0;
        bus.illegal     <= live & illegal_p0;
      end
    end
  end

endmodule

// File: tb/tb_instruction_decode.sv
// ---------------------------------------------------------------------------
// tb_instruction_decode
// Directed vectors for the RV32I decode stage. Each issued vector pushes its
// hand-computed expected ID/EX bundle, tagged with the cycle it must appear
// in, onto a scoreboard; a monitor on the falling edge pops and compares.
// ---------------------------------------------------------------------------
module tb_instruction_decode;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  instruction_decode_if #(.XLEN(32)) bus();

  instruction_decode #(.XLEN(32), .NREGS(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    string       name;
    int          tag;
    bit          full;   // 0: only id_valid and single-bit strobes are checked
    logic        valid;
    logic [31:0] pc;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] rs1_data, rs2_data, imm;
    logic [3:0]  alu_op;
    logic        alu_src_imm, reg_write, mem_read, mem_write;
    logic [2:0]  mem_size;
    logic        branch, jump, jalr, auipc, illegal;
  } exp_t;

  exp_t sb[$];

  function automatic exp_t mk(input string nm, input bit full);
    exp_t e;
    e.name = nm; e.tag = 0; e.full = full; e.valid = 0; e.pc = '0;
    e.rs1 = '0; e.rs2 = '0; e.rd = '0; e.rs1_data = '0; e.rs2_data = '0;
    e.imm = '0; e.alu_op = '0; e.alu_src_imm = 0; e.reg_write = 0;
    e.mem_read = 0; e.mem_write = 0; e.mem_size = '0; e.branch = 0;
    e.jump = 0; e.jalr = 0; e.auipc = 0; e.illegal = 0;
    return e;
  endfunction

  function automatic void chk(input string nm, input string f,
                              input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s.%s actual=0x%08h required=0x%08h (cycle %0d)", nm, f, act, exp, cyc);
    end
  endfunction

  task automatic compare(input exp_t e);
    chk(e.name, "id_valid",    32'(bus.id_valid),    32'(e.valid));
    chk(e.name, "alu_src_imm", 32'(bus.alu_src_imm), 32'(e.alu_src_imm));
    chk(e.name, "reg_write",   32'(bus.reg_write),   32'(e.reg_write));
    chk(e.name, "mem_read",    32'(bus.mem_read),    32'(e.mem_read));
    chk(e.name, "mem_write",   32'(bus.mem_write),   32'(e.mem_write));
    chk(e.name, "branch",      32'(bus.branch),      32'(e.branch));
    chk(e.name, "jump",        32'(bus.jump),        32'(e.jump));
    chk(e.name, "jalr",        32'(bus.jalr),        32'(e.jalr));
    chk(e.name, "auipc",       32'(bus.auipc),       32'(e.auipc));
    chk(e.name, "illegal",     32'(bus.illegal),     32'(e.illegal));
    if (e.full) begin
      chk(e.name, "pc_out",   bus.pc_out,        e.pc);
      chk(e.name, "rs1",      32'(bus.rs1),      32'(e.rs1));
      chk(e.name, "rs2",      32'(bus.rs2),      32'(e.rs2));
      chk(e.name, "rd",       32'(bus.rd),       32'(e.rd));
      chk(e.name, "rs1_data", bus.rs1_data,      e.rs1_data);
      chk(e.name, "rs2_data", bus.rs2_data,      e.rs2_data);
      chk(e.name, "imm",      bus.imm,           e.imm);
      chk(e.name, "alu_op",   32'(bus.alu_op),   32'(e.alu_op));
      chk(e.name, "mem_size", 32'(bus.mem_size), 32'(e.mem_size));
    end
  endtask

  // Monitor: compare every expectation due in the current cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].tag <= cyc) begin
        e = sb.pop_front();
        if (e.tag < cyc) begin
          n_chk++; n_fail++;
          $display("FAIL %s missed actual=cycle %0d required=cycle %0d", e.name, cyc, e.tag);
        end else compare(e);
      end
    end
  end

  task automatic issue(input logic [31:0] ins, input logic [31:0] pc, input logic v,
                       input logic en, input logic fl, input logic we,
                       input logic [4:0] wrd, input logic [31:0] wd, input exp_t e);
    bus.instr = ins; bus.pc_in = pc; bus.instr_valid = v; bus.enable = en;
    bus.flush = fl; bus.wb_en = we; bus.wb_rd = wrd; bus.wb_data = wd;
    e.tag = cyc + 1;
    sb.push_back(e);
    @(posedge clk); #1;
  endtask

  exp_t e, e_hold;

  initial begin
    bus.enable = 0; bus.flush = 0; bus.instr_valid = 0; bus.instr = '0;
    bus.pc_in = '0; bus.wb_en = 0; bus.wb_rd = '0; bus.wb_data = '0;

    // Power-on reset, checked while still asserted.
    #2 reset = 1'b0;
    @(posedge clk); #1;
    e = mk("por", 1); e.tag = cyc; sb.push_back(e);
    @(negedge clk); #1 reset = 1'b1;

    // Every register reads zero after reset: add x0, xi, xi.
    for (int i = 1; i < 32; i++) begin
      e = mk("rd_zero", 1); e.valid = 1; e.pc = 32'(i * 4);
      e.rs1 = 5'(i); e.rs2 = 5'(i); e.reg_write = 1;
      issue({7'b0, 5'(i), 5'(i), 3'b000, 5'b0, 7'b0110011}, 32'(i * 4), 1, 1, 0, 0, 0, 0, e);
    end

    // addi x1,x0,5 while writing x2 = 0xCAFEF00D.
    e = mk("addi", 1); e.valid = 1; e.pc = 32'h100; e.rd = 1; e.rs1 = 0; e.rs2 = 5;
    e.imm = 5; e.alu_src_imm = 1; e.reg_write = 1;
    issue(32'h00500093, 32'h100, 1, 1, 0, 1, 2, 32'hCAFEF00D, e);

    // sw x2,8(x1): x2 now holds the value written one edge earlier.
    e = mk("sw", 1); e.valid = 1; e.pc = 32'h104; e.rd = 8; e.rs1 = 1; e.rs2 = 2;
    e.rs2_data = 32'hCAFEF00D; e.imm = 8; e.alu_src_imm = 1; e.mem_write = 1; e.mem_size = 2;
    issue(32'h0020A423, 32'h104, 1, 1, 0, 0, 0, 0, e);

    // lui x5,0x12345
    e = mk("lui", 1); e.valid = 1; e.pc = 32'h108; e.rd = 5; e.rs1 = 8; e.rs2 = 3;
    e.imm = 32'h12345000; e.alu_op = 10; e.alu_src_imm = 1; e.reg_write = 1;
    issue(32'h123452B7, 32'h108, 1, 1, 0, 0, 0, 0, e);

    // beq x1,x2,-4
    e = mk("beq", 1); e.valid = 1; e.pc = 32'h10C; e.rd = 29; e.rs1 = 1; e.rs2 = 2;
    e.rs2_data = 32'hCAFEF00D; e.imm = 32'hFFFFFFFC; e.alu_op = 1; e.branch = 1;
    issue(32'hFE208EE3, 32'h10C, 1, 1, 0, 0, 0, 0, e);

    // add x3,x1,x2 with same-edge write of x1 -> bypass.
    e = mk("bypass", 1); e.valid = 1; e.pc = 32'h110; e.rd = 3; e.rs1 = 1; e.rs2 = 2;
    e.rs1_data = 32'hDEADBEEF; e.rs2_data = 32'hCAFEF00D; e.reg_write = 1;
    issue(32'h002081B3, 32'h110, 1, 1, 0, 1, 1, 32'hDEADBEEF, e);

    // add x4,x0,x0 with a write aimed at x0, then again without it.
    e = mk("x0_wr", 1); e.valid = 1; e.pc = 32'h114; e.rd = 4; e.reg_write = 1;
    issue(32'h00000233, 32'h114, 1, 1, 0, 1, 0, 32'hFFFFFFFF, e);
    e.name = "x0_rd"; e.pc = 32'h118;
    issue(32'h00000233, 32'h118, 1, 1, 0, 0, 0, 0, e);

    // add x6,x1,x0: x1 kept the bypassed value.
    e = mk("x1_rd", 1); e.valid = 1; e.pc = 32'h11C; e.rd = 6; e.rs1 = 1;
    e.rs1_data = 32'hDEADBEEF; e.reg_write = 1;
    issue(32'h00008333, 32'h11C, 1, 1, 0, 0, 0, 0, e);
    e_hold = e;

    // Three stall cycles; x1 is rewritten but the held operand must not change.
    e_hold.name = "stall";
    issue(32'hFFFFFFFF, 32'h999, 1, 0, 0, 1, 1, 32'h12345678, e_hold);
    issue(32'hFFFFFFFF, 32'h999, 1, 0, 0, 0, 0, 0, e_hold);
    issue(32'hFFFFFFFF, 32'h999, 1, 0, 0, 0, 0, 0, e_hold);

    // addi x1,x0,0x400: instr[30] set must not turn ADDI into SUB.
    e = mk("addi_b30", 1); e.valid = 1; e.pc = 32'h120; e.rd = 1;
    e.imm = 32'h400; e.alu_src_imm = 1; e.reg_write = 1;
    issue(32'h40000093, 32'h120, 1, 1, 0, 0, 0, 0, e);

    // srai x7,x1,3 reads the x1 written during the stall.
    e = mk("srai", 1); e.valid = 1; e.pc = 32'h124; e.rd = 7; e.rs1 = 1; e.rs2 = 3;
    e.rs1_data = 32'h12345678; e.imm = 32'h403; e.alu_op = 7; e.alu_src_imm = 1; e.reg_write = 1;
    issue(32'h4030D393, 32'h124, 1, 1, 0, 0, 0, 0, e);

    // Flush beats enable; instr_valid=0 gives the same bubble.
    e = mk("flush", 0);
    issue(32'h00500093, 32'h128, 1, 1, 1, 0, 0, 0, e);
    e.name = "bubble";
    issue(32'h00500093, 32'h12C, 0, 1, 0, 0, 0, 0, e);

    // Illegal word: flagged, no write strobes.
    e = mk("illegal", 0); e.valid = 1; e.illegal = 1;
    issue(32'hFFFFFFFF, 32'h130, 1, 1, 0, 0, 0, 0, e);

    // sw then lui back to back.
    e = mk("sw2", 1); e.valid = 1; e.pc = 32'h134; e.rd = 8; e.rs1 = 1; e.rs2 = 2;
    e.rs1_data = 32'h12345678; e.rs2_data = 32'hCAFEF00D; e.imm = 8;
    e.alu_src_imm = 1; e.mem_write = 1; e.mem_size = 2;
    issue(32'h0020A423, 32'h134, 1, 1, 0, 0, 0, 0, e);
    e = mk("lui2", 1); e.valid = 1; e.pc = 32'h138; e.rd = 5; e.rs1 = 8; e.rs2 = 3;
    e.imm = 32'h12345000; e.alu_op = 10; e.alu_src_imm = 1; e.reg_write = 1;
    issue(32'h123452B7, 32'h138, 1, 1, 0, 0, 0, 0, e);

    // Mid-stream reset right after an edge: outputs clear with no clock edge.
    @(negedge clk);
    @(posedge clk); #1;
    reset = 1'b0;
    e = mk("mid_rst", 1); e.tag = cyc; sb.push_back(e);
    @(negedge clk); #1 reset = 1'b1;

    // add x0,x1,x2: registers were cleared by the reset.
    e = mk("post_rst", 1); e.valid = 1; e.pc = 32'h200; e.rs1 = 1; e.rs2 = 2; e.reg_write = 1;
    issue(32'h00208033, 32'h200, 1, 1, 0, 0, 0, 0, e);

    bus.enable = 0; bus.wb_en = 0;
    for (int k = 0; k < 10 && sb.size() > 0; k++) @(posedge clk);
    @(negedge clk); #1;
    if (sb.size() != 0) begin
      n_chk++; n_fail++;
      $display("FAIL drain actual=%0d pending required=0 pending", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
